// File: rtl/store_buffer_lsu.sv
// Load/store front-end: a store FIFO drained by read-modify-write, with exact-match load
// forwarding, partial-overlap hazard stalls and single-port memory arbitration.
module store_buffer_lsu #(
  parameter int DEPTH     = 4,
  parameter int MEM_BYTES = 64,
  parameter int ADDR_W    = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_load,
  input  logic                           req_store,
  input  logic [2:0]                     funct3,
  input  logic [ADDR_W-1:0]              addr,
  input  logic [63:0]                    wdata,
  output logic [63:0]                    load_data,
  output logic                           stall,
  output logic                           fault,
  output logic [$clog2(DEPTH+1)-1:0]     buf_count,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic                           mem_read,
  output logic                           mem_write,
  output logic [63:0]                    mem_wdata,
  input  logic [63:0]                    mem_rdata
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] ent_addr_q [DEPTH];
  logic [3:0]        ent_n_q    [DEPTH];
  logic [63:0]       ent_data_q [DEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  logic [3:0]        req_n;
  logic [ADDR_W-1:0] limit;
  logic              oor, full, hit, exact;
  logic [PW-1:0]     hit_idx;
  logic [DEPTH-1:0]  overlap;
  logic              load_ok, store_ok, load_stall, store_stall, load_mem, drain, enq;
  logic [63:0]       merged;

  function automatic logic [63:0] extend(input logic [63:0] d, input logic [2:0] f3);
    case (f3)
      3'd0:    extend = {{56{d[7]}},  d[7:0]};
      3'd1:    extend = {{48{d[15]}}, d[15:0]};
      3'd2:    extend = {{32{d[31]}}, d[31:0]};
      3'd4:    extend = {56'd0, d[7:0]};
      3'd5:    extend = {48'd0, d[15:0]};
      3'd6:    extend = {32'd0, d[31:0]};
      default: extend = d;
    endcase
  endfunction

  // Comparing against MEM_BYTES-n instead of computing addr+n keeps huge addresses from wrapping.
  assign req_n = 4'd1 << funct3[1:0];
  assign limit = ADDR_W'(MEM_BYTES) - ADDR_W'(req_n);
  assign oor   = addr > limit;
  assign full  = count_q == CW'(DEPTH);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_ovl
      assign overlap[gi] = (ent_addr_q[gi] < addr + ADDR_W'(req_n)) &&
                           (addr < ent_addr_q[gi] + ADDR_W'(ent_n_q[gi]));
    end
    for (gi = 0; gi < 8; gi++) begin : g_merge
      assign merged[gi*8 +: 8] = (4'(gi) < ent_n_q[head_q]) ? ent_data_q[head_q][gi*8 +: 8]
                                                             : mem_rdata[gi*8 +: 8];
    end
  endgenerate

  // Walk oldest to youngest so the last match found is the youngest overlapping entry.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q && overlap[head_q + PW'(i)]) begin
        hit     = 1'b1;
        hit_idx = head_q + PW'(i);
      end
    end
  end

  assign exact       = hit && ent_addr_q[hit_idx] == addr && ent_n_q[hit_idx] == req_n;
  assign load_ok     = req_load && !oor;
  assign store_ok    = req_store && !oor;
  assign load_stall  = load_ok && (full || (hit && !exact));
  assign store_stall = store_ok && full;
  assign load_mem    = load_ok && !load_stall && !hit;
  assign drain       = (count_q != '0) && !load_mem;
  assign enq         = store_ok && !full;

  always_comb begin
    load_data = '0;
    stall     = 1'b0;
    fault     = 1'b0;
    mem_addr  = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_wdata = '0;
    buf_count = '0;
    if (!reset) begin
      buf_count = count_q;
      fault     = (req_load || req_store) && oor;
      stall     = load_stall || store_stall;
      if (drain) begin
        mem_addr  = ent_addr_q[head_q];
        mem_read  = 1'b1;
        mem_write = 1'b1;
        mem_wdata = merged;
      end else if (load_mem) begin
        mem_addr = addr;
        mem_read = 1'b1;
      end
      if (load_ok && !load_stall)
        load_data = exact ? extend(ent_data_q[hit_idx], funct3) : extend(mem_rdata, funct3);
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain) head_d = head_q + PW'(1);
    if (enq)   tail_d = tail_q + PW'(1);
    if (enq && !drain)      count_d = count_q + CW'(1);
    else if (!enq && drain) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (enq) begin
        ent_addr_q[tail_q] <= addr;
        ent_n_q[tail_q]    <= req_n;
        ent_data_q[tail_q] <= wdata;
      end
    end
  end
endmodule
